// File: rtl/mult_div.sv
// mult_div: multicycle signed multiply (radix-2 Booth) and divide (restoring)
// unit. The 2*DATA_W-bit result is held in HI/LO until the next completion.
module mult_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MULT    = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;

    // Shared iteration datapath: Booth {A, Q, q-1} or divide {remainder, quotient}
    logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
    logic [DATA_W:0]   acc_a_r,    acc_a_nxt_s;
    logic [DATA_W-1:0] acc_q_r,    acc_q_nxt_s;
    logic              acc_q1_r,   acc_q1_nxt_s;
    logic [DATA_W-1:0] opnd_b_r,   opnd_b_nxt_s;
    logic              neg_quo_r,  neg_quo_nxt_s;
    logic              neg_rem_r,  neg_rem_nxt_s;
    logic [DATA_W-1:0] hi_r,       hi_nxt_s;
    logic [DATA_W-1:0] lo_r,       lo_nxt_s;
    logic              busy_r,     busy_nxt_s;
    logic              done_r,     done_nxt_s;
    logic              div_zero_r, div_zero_nxt_s;

    // Booth step and restoring-divide step, both derived from the current state
    logic [DATA_W:0]   b_ext_s;
    logic [DATA_W:0]   booth_sum_s;
    logic [DATA_W:0]   booth_a_s;
    logic [DATA_W-1:0] booth_q_s;
    logic [DATA_W:0]   div_shift_s;
    logic [DATA_W:0]   div_trial_s;
    logic              div_ok_s;
    logic [DATA_W:0]   div_rem_s;
    logic [DATA_W-1:0] div_quo_s;
    logic [DATA_W-1:0] a_abs_s;
    logic [DATA_W-1:0] b_abs_s;
    logic [DATA_W-1:0] rem_mag_s;

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

    // Single-iteration arithmetic for multiply and divide plus operand magnitudes
    always_comb begin
        b_ext_s = {opnd_b_r[DATA_W-1], opnd_b_r};
        case ({acc_q_r[0], acc_q1_r})
            2'b01:   booth_sum_s = acc_a_r + b_ext_s;
            2'b10:   booth_sum_s = acc_a_r - b_ext_s;
            default: booth_sum_s = acc_a_r;
        endcase
        booth_a_s   = {booth_sum_s[DATA_W], booth_sum_s[DATA_W:1]};
        booth_q_s   = {booth_sum_s[0], acc_q_r[DATA_W-1:1]};

        div_shift_s = {acc_a_r[DATA_W-1:0], acc_q_r[DATA_W-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_b_r};
        div_ok_s    = ~div_trial_s[DATA_W];
        if (div_ok_s) begin
            div_rem_s = div_trial_s;
        end else begin
            div_rem_s = div_shift_s;
        end
        div_quo_s   = {acc_q_r[DATA_W-2:0], div_ok_s};

        if (a[DATA_W-1]) begin
            a_abs_s = {DATA_W{1'b0}} - a;
        end else begin
            a_abs_s = a;
        end
        if (b[DATA_W-1]) begin
            b_abs_s = {DATA_W{1'b0}} - b;
        end else begin
            b_abs_s = b;
        end
        rem_mag_s = acc_a_r[DATA_W-1:0];
    end

    // Next-state and next-register-value logic for the control FSM
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        acc_a_nxt_s    = acc_a_r;
        acc_q_nxt_s    = acc_q_r;
        acc_q1_nxt_s   = acc_q1_r;
        opnd_b_nxt_s   = opnd_b_r;
        neg_quo_nxt_s  = neg_quo_r;
        neg_rem_nxt_s  = neg_rem_r;
        hi_nxt_s       = hi_r;
        lo_nxt_s       = lo_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        div_zero_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (mult_start) begin
                    // Multiply has priority; a simultaneous divide is dropped
                    state_nxt_s  = ST_MULT;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    acc_a_nxt_s  = {(DATA_W+1){1'b0}};
                    acc_q_nxt_s  = a;
                    acc_q1_nxt_s = 1'b0;
                    opnd_b_nxt_s = b;
                    busy_nxt_s   = 1'b1;
                end else if (div_start) begin
                    if (b == {DATA_W{1'b0}}) begin
                        div_zero_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_DIV;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        acc_a_nxt_s   = {(DATA_W+1){1'b0}};
                        acc_q_nxt_s   = a_abs_s;
                        opnd_b_nxt_s  = b_abs_s;
                        neg_quo_nxt_s = a[DATA_W-1] ^ b[DATA_W-1];
                        neg_rem_nxt_s = a[DATA_W-1];
                        busy_nxt_s    = 1'b1;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_MULT: begin
                acc_a_nxt_s  = booth_a_s;
                acc_q_nxt_s  = booth_q_s;
                acc_q1_nxt_s = acc_q_r[0];
                if (cnt_r == CNT_LAST) begin
                    // Final iteration writes the product straight into HI/LO
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    hi_nxt_s    = booth_a_s[DATA_W-1:0];
                    lo_nxt_s    = booth_q_s;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DIV: begin
                acc_a_nxt_s = div_rem_s;
                acc_q_nxt_s = div_quo_s;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DIV_FIX;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                // Truncating division: quotient sign a^b, remainder sign of a
                if (neg_quo_r) begin
                    lo_nxt_s = {DATA_W{1'b0}} - acc_q_r;
                end else begin
                    lo_nxt_s = acc_q_r;
                end
                if (neg_rem_r) begin
                    hi_nxt_s = {DATA_W{1'b0}} - rem_mag_s;
                end else begin
                    hi_nxt_s = rem_mag_s;
                end
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset discards any partial result
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            acc_a_r    <= {(DATA_W+1){1'b0}};
            acc_q_r    <= {DATA_W{1'b0}};
            acc_q1_r   <= 1'b0;
            opnd_b_r   <= {DATA_W{1'b0}};
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            hi_r       <= {DATA_W{1'b0}};
            lo_r       <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            acc_a_r    <= acc_a_nxt_s;
            acc_q_r    <= acc_q_nxt_s;
            acc_q1_r   <= acc_q1_nxt_s;
            opnd_b_r   <= opnd_b_nxt_s;
            neg_quo_r  <= neg_quo_nxt_s;
            neg_rem_r  <= neg_rem_nxt_s;
            hi_r       <= hi_nxt_s;
            lo_r       <= lo_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            div_zero_r <= div_zero_nxt_s;
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed vectors with hand-computed results for mult_div.
module tb_mult_div;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              mult_start;
    logic              div_start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_zero;

    int checks;
    int failures;
    int n_cyc;

    mult_div #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done, bounded; returns the number of edges taken
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            step();
            n = n + 1;
        end
    endtask

    task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        mult_start = m;
        div_start  = d;
        a          = av;
        b          = bv;
        step();
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = 32'hDEAD_BEEF;
        b          = 32'h0000_0000;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        step();
        step();
        check_val("rst_hi",   64'(hi), 64'h0);
        check_val("rst_lo",   64'(lo), 64'h0);
        check_val("rst_busy", 64'(busy), 64'h0);
        check_val("rst_done", 64'(done), 64'h0);
        check_val("rst_dz",   64'(div_zero), 64'h0);
        reset = 1'b1;
        step();

        // 7 * -3 = -21
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check_val("m1_busy", 64'(busy), 64'h1);
        check_val("m1_done0", 64'(done), 64'h0);
        wait_done(n_cyc);
        check_val("m1_lat",  64'(n_cyc), 64'd32);
        check_val("m1_busy_at_done", 64'(busy), 64'h0);
        check_val("m1_hi",   64'(hi), 64'hFFFF_FFFF);
        check_val("m1_lo",   64'(lo), 64'hFFFF_FFEB);
        step();
        check_val("m1_done_pulse", 64'(done), 64'h0);

        // min * min, then back-to-back 3 * 5 started in the done cycle
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(n_cyc);
        check_val("m2_lat", 64'(n_cyc), 64'd32);
        check_val("m2_hi",  64'(hi), 64'h4000_0000);
        check_val("m2_lo",  64'(lo), 64'h0000_0000);
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        check_val("m3_busy", 64'(busy), 64'h1);
        wait_done(n_cyc);
        check_val("m3_lat", 64'(n_cyc), 64'd32);
        check_val("m3_hi",  64'(hi), 64'h0);
        check_val("m3_lo",  64'(lo), 64'd15);
        step();

        // -7 / 2 = -3 rem -1
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_val("d1_busy", 64'(busy), 64'h1);
        wait_done(n_cyc);
        check_val("d1_lat", 64'(n_cyc), 64'd33);
        check_val("d1_lo",  64'(lo), 64'hFFFF_FFFD);
        check_val("d1_hi",  64'(hi), 64'hFFFF_FFFF);
        step();

        // 7 / -2 = -3 rem 1
        start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(n_cyc);
        check_val("d2_lat", 64'(n_cyc), 64'd33);
        check_val("d2_lo",  64'(lo), 64'hFFFF_FFFD);
        check_val("d2_hi",  64'(hi), 64'h1);
        step();

        // Restore hi/lo = 0/15, then divide by zero must leave them alone
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        wait_done(n_cyc);
        check_val("m4_lo", 64'(lo), 64'd15);
        step();
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        check_val("dz_pulse", 64'(div_zero), 64'h1);
        check_val("dz_busy",  64'(busy), 64'h0);
        check_val("dz_done",  64'(done), 64'h0);
        check_val("dz_hi",    64'(hi), 64'h0);
        check_val("dz_lo",    64'(lo), 64'd15);
        step();
        check_val("dz_pulse_end", 64'(div_zero), 64'h0);
        check_val("dz_busy2",     64'(busy), 64'h0);
        check_val("dz_done2",     64'(done), 64'h0);

        // Overflow case wraps silently
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n_cyc);
        check_val("d3_lat", 64'(n_cyc), 64'd33);
        check_val("d3_lo",  64'(lo), 64'h8000_0000);
        check_val("d3_hi",  64'(hi), 64'h0);
        check_val("d3_done", 64'(done), 64'h1);
        check_val("d3_dz",  64'(div_zero), 64'h0);
        step();

        // Simultaneous starts: multiply wins
        start_op(1'b1, 1'b1, 32'd6, 32'd4);
        wait_done(n_cyc);
        check_val("both_lat", 64'(n_cyc), 64'd32);
        check_val("both_lo",  64'(lo), 64'd24);
        check_val("both_hi",  64'(hi), 64'h0);
        step();

        // Divide request mid-multiply is ignored (b=0 would pulse div_zero)
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        for (int i = 0; i < 9; i++) step();
        div_start = 1'b1;
        a         = 32'd100;
        b         = 32'd0;
        step();
        div_start = 1'b0;
        check_val("ign_dz",   64'(div_zero), 64'h0);
        check_val("ign_busy", 64'(busy), 64'h1);
        wait_done(n_cyc);
        check_val("ign_lat", 64'(n_cyc + 10), 64'd32);
        check_val("ign_hi",  64'(hi), 64'hFFFF_FFFF);
        check_val("ign_lo",  64'(lo), 64'hFFFF_FFEB);
        step();

        // Reset at iteration 20 aborts and clears; coincident start ignored
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        for (int i = 0; i < 19; i++) step();
        reset      = 1'b0;
        mult_start = 1'b1;
        a          = 32'd9;
        b          = 32'd9;
        step();
        reset      = 1'b1;
        mult_start = 1'b0;
        check_val("rst2_hi",   64'(hi), 64'h0);
        check_val("rst2_lo",   64'(lo), 64'h0);
        check_val("rst2_busy", 64'(busy), 64'h0);
        check_val("rst2_done", 64'(done), 64'h0);
        check_val("rst2_dz",   64'(div_zero), 64'h0);
        step();
        step();
        check_val("rst2_idle", 64'(busy), 64'h0);
        check_val("rst2_done_idle", 64'(done), 64'h0);

        // Fresh multiply after reset: -6 * -7 = 42
        start_op(1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
        wait_done(n_cyc);
        check_val("post_lat", 64'(n_cyc), 64'd32);
        check_val("post_hi",  64'(hi), 64'h0);
        check_val("post_lo",  64'(lo), 64'd42);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
